// File: rtl/decimal_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decimal_entry_pkg
// Brief    : Shared types and constants for the decimal entry front-end.
// Revision : 1.0 - initial release
// ============================================================================
package decimal_entry_pkg;

  // Entry FSM states
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  localparam int NUM_DIGITS = 3;
  localparam int MAX_MAG    = 999;
  localparam int ACC_W      = 10;

  // True for key codes 0..9
  function automatic logic is_decimal(input bcd_t d);
    return (d <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decimal_entry_to_binary_mac10.sv
`default_nettype none
// ============================================================================
// Module   : mac10
// Brief    : Combinational acc*10 + digit, multiply built from two shifts.
// Revision : 1.0 - initial release
// ============================================================================
module mac10
  import decimal_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  bcd_t             digit,
  output logic [ACC_W-1:0] acc_out
);

  // acc*10 = acc*8 + acc*2; the result never exceeds 999 so 10 bits suffice
  assign acc_out = (acc_in << 3) + (acc_in << 1) + ACC_W'(digit);

endmodule
`default_nettype wire

// File: rtl/decimal_entry_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : decimal_entry_to_binary
// Brief    : Keypad entry of up to 3 decimal digits with sign, backspace,
//            clear and enter; converts to signed-magnitude or two's
//            complement binary over three accumulate cycles.
// Revision : 1.0 - initial release
// ============================================================================
module decimal_entry_to_binary
  import decimal_entry_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         DigitValid,
  input  logic [3:0]   Digit,
  input  logic         Negate,
  input  logic         Backspace,
  input  logic         Clear,
  input  logic         Enter,
  input  logic         Encoding,
  output logic [W-1:0] N,
  output logic         Valid,
  output logic         Ready,
  output logic         Busy,
  output logic         BadKey,
  output logic [1:0]   Count,
  output logic         Negative
);

  state_t           state;
  bcd_t             b2, b1, b0;
  logic [ACC_W-1:0] acc;
  logic [1:0]       step;
  logic             enc_latched;

  logic             key_enter, key_back, key_neg, key_digit;
  logic             digit_ok;
  bcd_t             step_digit;
  logic [ACC_W-1:0] mac_out;
  logic             sign;
  logic [W-1:0]     ext;
  logic [W-1:0]     result;

  // Key priority: Clear > Enter > Backspace > Negate > DigitValid
  always_comb begin
    key_enter = !Clear && Enter;
    key_back  = !Clear && !Enter && Backspace;
    key_neg   = !Clear && !Enter && !Backspace && Negate;
    key_digit = !Clear && !Enter && !Backspace && !Negate && DigitValid;
    digit_ok  = is_decimal(Digit);
  end

  // Select the BCD digit consumed by this conversion step, most significant first
  always_comb begin
    step_digit = b0;
    case (step)
      2'd0:    step_digit = b2;
      2'd1:    step_digit = b1;
      default: step_digit = b0;
    endcase
  end

  mac10 u_mac10 (
    .acc_in  (acc),
    .digit   (step_digit),
    .acc_out (mac_out)
  );

  // Final encoding of the accumulated magnitude; a zero magnitude is always positive
  always_comb begin
    ext  = {{(W-ACC_W){1'b0}}, acc};
    sign = Negative && (acc != '0);
    if (enc_latched) begin
      result = sign ? -ext : ext;
    end else begin
      result        = ext;
      result[W-1]   = sign;
    end
  end

  assign Busy  = (state == CONVERT);
  assign Ready = (state == DONE);

  // Entry FSM, BCD buffer, conversion stepping and output register
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state       <= EMPTY;
      b2          <= '0;
      b1          <= '0;
      b0          <= '0;
      Count       <= '0;
      Negative    <= 1'b0;
      acc         <= '0;
      step        <= '0;
      enc_latched <= 1'b0;
      N           <= '0;
      Valid       <= 1'b0;
      BadKey      <= 1'b0;
    end else begin
      Valid  <= 1'b0;
      BadKey <= 1'b0;
      if (Clear) begin
        // Abandon the entry in any state; N keeps its last result
        state    <= EMPTY;
        b2       <= '0;
        b1       <= '0;
        b0       <= '0;
        Count    <= '0;
        Negative <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (key_enter) begin
              state       <= CONVERT;
              acc         <= '0;
              step        <= '0;
              enc_latched <= Encoding;
            end else if (key_neg) begin
              Negative <= !Negative;
            end else if (key_digit) begin
              if (!digit_ok) begin
                BadKey <= 1'b1;
              end else if (Digit != 4'd0) begin
                b0    <= Digit;
                Count <= 2'd1;
                state <= ENTRY;
              end
            end
          end

          ENTRY: begin
            if (key_enter) begin
              state       <= CONVERT;
              acc         <= '0;
              step        <= '0;
              enc_latched <= Encoding;
            end else if (key_back) begin
              b0    <= b1;
              b1    <= b2;
              b2    <= '0;
              Count <= Count - 2'd1;
              if (Count == 2'd1) state <= EMPTY;
            end else if (key_neg) begin
              Negative <= !Negative;
            end else if (key_digit) begin
              if (!digit_ok || Count == 2'(NUM_DIGITS)) begin
                BadKey <= 1'b1;
              end else begin
                b2    <= b1;
                b1    <= b0;
                b0    <= Digit;
                Count <= Count + 2'd1;
              end
            end
          end

          CONVERT: begin
            // Steps 0..2 accumulate B2,B1,B0; step 3 loads the result
            if (step == 2'd3) begin
              N     <= result;
              Valid <= 1'b1;
              state <= DONE;
              if (acc == '0) Negative <= 1'b0;
            end else begin
              acc  <= mac_out;
              step <= step + 2'd1;
            end
          end

          DONE: begin
            if (key_enter) begin
              state       <= CONVERT;
              acc         <= '0;
              step        <= '0;
              enc_latched <= Encoding;
            end else if (key_back) begin
              b0 <= b1;
              b1 <= b2;
              b2 <= '0;
              if (Count != 2'd0) Count <= Count - 2'd1;
              state <= (Count <= 2'd1) ? EMPTY : ENTRY;
            end else if (key_neg) begin
              Negative <= !Negative;
              state    <= (Count == 2'd0) ? EMPTY : ENTRY;
            end else if (key_digit) begin
              if (!digit_ok) begin
                BadKey <= 1'b1;
              end else begin
                // A fresh digit starts a new entry
                b2       <= '0;
                b1       <= '0;
                b0       <= Digit;
                Negative <= 1'b0;
                if (Digit == 4'd0) begin
                  b0    <= '0;
                  Count <= 2'd0;
                  state <= EMPTY;
                end else begin
                  Count <= 2'd1;
                  state <= ENTRY;
                end
              end
            end
          end

          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
